// File: rtl/torso_audio_pkg.sv
// Shared definitions for the audio tone path.
// Contents:
//   LFSR_W, SEED_DEFAULT  LFSR width and default reset value (nonzero)
//   TAP_*                 feedback taps for x^16+x^14+x^13+x^11+1
//   MIN_HALF_DEFAULT,
//   STEP_LOG2_DEFAULT     default tone table parameters
//   tone_half()           half-period in clocks for a tone index
package torso_audio_pkg;

    localparam int unsigned   LFSR_W            = 16;
    localparam logic [15:0]   SEED_DEFAULT      = 16'hACE1;
    localparam int unsigned   TAP_A             = 15;
    localparam int unsigned   TAP_B             = 13;
    localparam int unsigned   TAP_C             = 12;
    localparam int unsigned   TAP_D             = 10;
    localparam int unsigned   MIN_HALF_DEFAULT  = 6250;
    localparam int unsigned   STEP_LOG2_DEFAULT = 10;

    // Linear tone table: each index step lengthens the half-period by 2^step_log2.
    function automatic int unsigned tone_half(
        input int unsigned idx,
        input int unsigned min_half  = MIN_HALF_DEFAULT,
        input int unsigned step_log2 = STEP_LOG2_DEFAULT
    );
        return min_half + (idx << step_log2);
    endfunction

endpackage

// File: rtl/torso_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
// Ports:
//   clk  system clock
//   rst  synchronous active-low reset, loads SEED
//   q    current LFSR state (never zero for a nonzero SEED)
module torso_lfsr16
    import torso_audio_pkg::*;
#(
    parameter logic [15:0] SEED = SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] q_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= SEED;
        end else begin
            q_q <= {q_q[14:0], q_q[TAP_A] ^ q_q[TAP_B] ^ q_q[TAP_C] ^ q_q[TAP_D]};
        end
    end

    assign q = q_q;

endmodule

// File: rtl/random_tone_generator.sv
// Picks a pseudo-random tone on every rising edge of the asynchronous `sec`
// marker and plays it as a square wave. Tone changes are deferred to the
// next square-wave edge so the output never produces a runt pulse.
// Ports:
//   clk       system clock
//   rst       synchronous active-low reset (aborts any tone in progress)
//   sec       second marker, asynchronous level
//   en        audio enable; when low the output is held low and the divider idles
//   audio     square-wave output
//   tone_idx  index of the most recently selected tone
//   new_tone  one-clock pulse when a new tone index is latched
module random_tone_generator
    import torso_audio_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 25000000,
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned MIN_HALF  = MIN_HALF_DEFAULT,
    parameter int unsigned STEP_LOG2 = STEP_LOG2_DEFAULT,
    parameter int unsigned CNT_W     = 17,
    parameter logic [15:0] SEED      = SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sec,
    input  logic             en,
    output logic             audio,
    output logic [IDX_W-1:0] tone_idx,
    output logic             new_tone
);

    // Elaboration-time sanity checks on the parameter set.
    if (SEED == 16'h0) begin : g_seed_chk
        $error("SEED must be nonzero");
    end
    if (tone_half((1 << IDX_W) - 1, MIN_HALF, STEP_LOG2) >= (64'd1 << CNT_W)) begin : g_cnt_chk
        $error("CNT_W too narrow for the longest half-period");
    end
    if (CLK_HZ < 2 * MIN_HALF) begin : g_clk_chk
        $error("CLK_HZ too low for MIN_HALF");
    end

    logic [15:0]      lfsr;
    logic             s1_q, s2_q, s3_q;
    logic             sec_edge;
    logic             pend_q, pend_d;
    logic             playing_q, playing_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             audio_q, audio_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             new_q, new_d;
    logic [CNT_W-1:0] target;
    logic             wrap;
    logic             take;
    logic             unused_lfsr;

    torso_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:IDX_W];

    assign sec_edge = s2_q & ~s3_q;
    assign target   = CNT_W'(tone_half(32'(idx_q), MIN_HALF, STEP_LOG2));
    assign wrap     = (cnt_q == half_q - CNT_W'(1));

    always_comb begin
        pend_d    = pend_q;
        playing_d = playing_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        audio_d   = audio_q;
        idx_d     = idx_q;
        new_d     = sec_edge;
        take      = 1'b0;

        if (!playing_q) begin
            audio_d = 1'b0;
            cnt_d   = '0;
            if (pend_q && en) begin
                half_d    = target;
                playing_d = 1'b1;
                take      = 1'b1;
            end
        end else if (!en) begin
            // Muted: divider parked at the start of a low phase. A pending
            // tone is loaded now so that re-enable starts on the latest one.
            audio_d = 1'b0;
            cnt_d   = '0;
            if (pend_q) begin
                half_d = target;
                take   = 1'b1;
            end
        end else if (wrap) begin
            cnt_d   = '0;
            audio_d = ~audio_q;
            if (pend_q) begin
                half_d = target;
                take   = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A new edge outranks consumption: the consumer saw the old tone.
        if (take) pend_d = 1'b0;
        if (sec_edge) begin
            pend_d = 1'b1;
            idx_d  = lfsr[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            pend_q    <= 1'b0;
            playing_q <= 1'b0;
            cnt_q     <= '0;
            half_q    <= CNT_W'(MIN_HALF);
            audio_q   <= 1'b0;
            idx_q     <= '0;
            new_q     <= 1'b0;
        end else begin
            s1_q      <= sec;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            pend_q    <= pend_d;
            playing_q <= playing_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            audio_q   <= audio_d;
            idx_q     <= idx_d;
            new_q     <= new_d;
        end
    end

    assign audio    = audio_q;
    assign tone_idx = idx_q;
    assign new_tone = new_q;

endmodule
